// File: rtl/mem_bus_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch and data access (data first).
// Optional ack-timeout abort with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [1:0]        FETCH_SIZE  = 2'b00,
    parameter logic [DATA_W-1:0] NOP_INST    = 32'h0000_0013,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_hold,
    input  logic              dm_req,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [1:0]        dm_size,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_hold,
    output logic              bus_req,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_size,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_pipe,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    // Handshake: bus_req/bus_* are held from grant until the edge where bus_ack=1 is
    // sampled; that edge completes the transaction and the bus returns to all zeros.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_FETCH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_write_q, bus_write_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [1:0]          bus_size_q, bus_size_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_hold_q, if_hold_d;
    logic                dm_hold_q, dm_hold_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                bus_err_q, bus_err_d;
`endif

    // A request is pending until its hold flag shows the result is in place.
    assign stall_pipe = (dm_req & ~dm_hold_q) | (if_req & ~if_hold_q);

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_size_d  = bus_size_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_hold_d   = if_hold_q;
        dm_hold_d   = dm_hold_q;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        bus_err_d   = bus_err_q;
`endif

        // Pipeline advances on this edge, so the completed set is consumed.
        if (!stall_pipe) begin
            if_hold_d = 1'b0;
            dm_hold_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (dm_req && !dm_hold_q) begin
                    state_d     = S_DATA;
                    bus_req_d   = 1'b1;
                    bus_write_d = dm_write;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                    bus_size_d  = dm_size;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end else if (if_req && !if_hold_q) begin
                    state_d     = S_FETCH;
                    bus_req_d   = 1'b1;
                    bus_write_d = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_size_d  = FETCH_SIZE;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end
            end

            S_DATA, S_FETCH: begin
                if (bus_ack) begin
                    state_d     = S_IDLE;
                    bus_req_d   = 1'b0;
                    bus_write_d = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_size_d  = 2'b00;
                    if (state_q == S_DATA) begin
                        dm_hold_d = 1'b1;
                        if (!bus_write_q) begin
                            dm_rdata_d = bus_rdata;
                        end
                    end else begin
                        if_hold_d  = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abort: the requester still sees completion, with a safe dummy result.
                    state_d     = S_IDLE;
                    bus_req_d   = 1'b0;
                    bus_write_d = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_size_d  = 2'b00;
                    bus_err_d   = 1'b1;
                    if (state_q == S_DATA) begin
                        dm_hold_d = 1'b1;
                        if (!bus_write_q) begin
                            dm_rdata_d = '0;
                        end
                    end else begin
                        if_hold_d  = 1'b1;
                        if_rdata_d = NOP_INST;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end

            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_size_q  <= 2'b00;
            if_rdata_q  <= NOP_INST;
            dm_rdata_q  <= '0;
            if_hold_q   <= 1'b0;
            dm_hold_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_size_q  <= bus_size_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_hold_q   <= if_hold_d;
            dm_hold_q   <= dm_hold_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign bus_req   = bus_req_q;
    assign bus_write = bus_write_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_size  = bus_size_q;
    assign if_rdata  = if_rdata_q;
    assign if_hold   = if_hold_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_hold   = dm_hold_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: memory responder with planned ack delays, request-set model, bus/result scoreboard.
module tb_mem_bus_arbiter;

    localparam logic [1:0]  FETCH_SIZE = 2'b00;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [1:0]  dm_size;
    logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        if_hold, dm_hold, bus_req, bus_write, bus_ack, stall_pipe, bus_err;
    logic [1:0]  bus_size, dbg_state;

    logic        resp_en, resp_ack, man_ack;
    logic [31:0] resp_rdata, man_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [66:0] exp_bus_q[$];
    logic [31:0] exp_dm_q[$];
    logic [31:0] exp_if_q[$];
    int          dly_q[$];

    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ref_dm;

    assign bus_ack   = resp_ack | man_ack;
    assign bus_rdata = man_ack ? man_rdata : resp_rdata;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_hold(if_hold),
        .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_hold(dm_hold),
        .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_size(bus_size), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall_pipe(stall_pipe), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Memory environment: acks each bus transaction after the delay planned by the stimulus.
    initial begin
        int d;
        resp_ack   = 1'b0;
        resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en && rst && bus_req) begin
                d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                repeat (d) @(negedge clk);
                resp_rdata = bus_write ? 32'h0 : mem_rd(bus_addr);
                if (bus_write) mem[bus_addr] = bus_wdata;
                resp_ack = 1'b1;
                @(posedge clk);
                #1 resp_ack = 1'b0;
            end
        end
    end

    // Monitor: compares each granted transaction, each completion, and stability of held values.
    logic        bus_req_p, if_hold_p, dm_hold_p;
    logic [66:0] cur_bus, t_bus;
    logic [31:0] if_val, dm_val;

    always @(negedge clk) begin
        if (!rst) begin
            bus_req_p = 1'b0;
            if_hold_p = 1'b0;
            dm_hold_p = 1'b0;
        end else begin
            if (bus_req && !bus_req_p) begin
                cur_bus = {bus_write, bus_size, bus_addr, bus_wdata};
                if (exp_bus_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_bus_txn: got addr %0h expected none", bus_addr);
                end else begin
                    t_bus = exp_bus_q.pop_front();
                    check("bus_addr", {35'h0, bus_addr}, {35'h0, t_bus[63:32]});
                    check("bus_write", {66'h0, bus_write}, {66'h0, t_bus[66]});
                    check("bus_size", {65'h0, bus_size}, {65'h0, t_bus[65:64]});
                    if (t_bus[66]) check("bus_wdata", {35'h0, bus_wdata}, {35'h0, t_bus[31:0]});
                end
            end else if (bus_req) begin
                check("bus_stable", {bus_write, bus_size, bus_addr, bus_wdata}, cur_bus);
            end

            if (dm_hold && !dm_hold_p) begin
                dm_val = dm_rdata;
                if (exp_dm_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_dm_hold: got %0h expected none", dm_rdata);
                end else begin
                    check("dm_rdata", {35'h0, dm_rdata}, {35'h0, exp_dm_q.pop_front()});
                end
            end else if (dm_hold) begin
                check("dm_rdata_held", {35'h0, dm_rdata}, {35'h0, dm_val});
            end

            if (if_hold && !if_hold_p) begin
                if_val = if_rdata;
                if (exp_if_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_if_hold: got %0h expected none", if_rdata);
                end else begin
                    check("if_rdata", {35'h0, if_rdata}, {35'h0, exp_if_q.pop_front()});
                end
            end else if (if_hold) begin
                check("if_rdata_held", {35'h0, if_rdata}, {35'h0, if_val});
            end

            bus_req_p = bus_req;
            if_hold_p = if_hold;
            dm_hold_p = dm_hold;
        end
    end

    // One request set: data (if any) then fetch (if any); each costs a grant cycle plus 1+delay bus cycles.
    task automatic step(input logic dv, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [1:0] dsz, input int ddly,
                        input logic fv, input logic [31:0] fa, input int fdly);
        int  exp_stall;
        int  n;
        logic done;
        exp_stall = 0;
        if (dv) begin
            exp_bus_q.push_back({dw, dsz, da, dwd});
            dly_q.push_back(ddly);
            exp_stall += 2 + ddly;
            if (dw) ref_mem[da] = dwd;
            else    ref_dm = ref_rd(da);
            exp_dm_q.push_back(ref_dm);
        end
        if (fv) begin
            exp_bus_q.push_back({1'b0, FETCH_SIZE, fa, 32'h0});
            dly_q.push_back(fdly);
            exp_stall += 2 + fdly;
            exp_if_q.push_back(ref_rd(fa));
        end
        dm_req = dv; dm_write = dw; dm_addr = da; dm_wdata = dwd; dm_size = dsz;
        if_req = fv; if_addr = fa;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!stall_pipe) begin
                done = 1'b1;
                break;
            end
            n++;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL stall_timeout: stall_pipe still high after %0d cycles, required drop after %0d", n, exp_stall);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
        check("stall_cycles", 67'(n), 67'(exp_stall));
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        if_req = 1'b0;
    endtask

    initial begin
        int   kind;
        logic dv, fv, dw;
        logic [31:0] da, fa, wd;
        int n;

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = 2'b00;
        resp_en = 1'b1; man_ack = 1'b0; man_rdata = '0;
        ref_dm = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_req", {66'h0, bus_req}, 67'h0);
        check("rst_bus_fields", {bus_write, bus_size, bus_addr, bus_wdata}, 67'h0);
        check("rst_if_rdata", {35'h0, if_rdata}, {35'h0, NOP});
        check("rst_dm_rdata", {35'h0, dm_rdata}, 67'h0);
        check("rst_holds", {65'h0, if_hold, dm_hold}, 67'h0);
        check("rst_bus_err", {66'h0, bus_err}, 67'h0);
        check("rst_stall", {66'h0, stall_pipe}, 67'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch with an immediate ack.
        preload(32'h0001_0000, 32'h0050_0093);
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 0, 1'b1, 32'h0001_0000, 0);

        // Load and fetch together: data first, four stall cycles.
        preload(32'h0000_2000, 32'hCAFE_F00D);
        step(1'b1, 1'b0, 32'h0000_2000, 32'h0, 2'b10, 0, 1'b1, 32'h0001_0004, 0);

        // Store with a three-cycle ack delay; dm_rdata keeps the previous load value.
        step(1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 2'b00, 3, 1'b0, 32'h0, 0);

        // Ack pulse in IDLE with nothing pending.
        @(posedge clk);
        #1 man_ack = 1'b1; man_rdata = 32'h1111_2222;
        @(posedge clk);
        #1 man_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_holds", {65'h0, if_hold, dm_hold}, 67'h0);
        check("idle_ack_bus_req", {66'h0, bus_req}, 67'h0);
        check("idle_ack_dm_rdata", {35'h0, dm_rdata}, {35'h0, ref_dm});
        @(posedge clk);
        #1;

        // Reset in the middle of a fetch, then a stray ack.
        resp_en = 1'b0;
        exp_bus_q.push_back({1'b0, FETCH_SIZE, 32'h0000_3000, 32'h0});
        if_req = 1'b1; if_addr = 32'h0000_3000;
        @(negedge clk);
        @(negedge clk);
        check("mid_fetch_bus_req", {66'h0, bus_req}, 67'h1);
        #2 rst = 1'b0;
        if_req = 1'b0;
        #1;
        check("async_rst_bus_req", {66'h0, bus_req}, 67'h0);
        check("async_rst_bus_addr", {35'h0, bus_addr}, 67'h0);
        check("async_rst_if_rdata", {35'h0, if_rdata}, {35'h0, NOP});
        check("async_rst_dm_rdata", {35'h0, dm_rdata}, 67'h0);
        ref_dm = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 man_ack = 1'b0;
        @(negedge clk);
        check("late_ack_if_hold", {66'h0, if_hold}, 67'h0);
        check("late_ack_if_rdata", {35'h0, if_rdata}, {35'h0, NOP});
        check("late_ack_bus_req", {66'h0, bus_req}, 67'h0);
        @(posedge clk);
        #1 resp_en = 1'b1;

`ifdef MEM_TIMEOUT_EN
        // Fetch that is never acknowledged.
        resp_en = 1'b0;
        exp_bus_q.push_back({1'b0, FETCH_SIZE, 32'h0000_4000, 32'h0});
        exp_if_q.push_back(NOP);
        if_req = 1'b1; if_addr = 32'h0000_4000;
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus_req) break;
            n++;
        end
        check("timeout_wait_cycles", 67'(n), 67'd16);
        check("timeout_if_hold", {66'h0, if_hold}, 67'h1);
        check("timeout_bus_err", {66'h0, bus_err}, 67'h1);
        @(posedge clk);
        #1 if_req = 1'b0;
        resp_en = 1'b1;
`endif

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            dv = (kind != 1);
            fv = (kind != 0);
            dw = 1'($urandom_range(0, 1));
            da = 32'h0000_2000 + 32'($urandom_range(0, 15)) * 4;
            fa = 32'h0000_2000 + 32'($urandom_range(0, 15)) * 4;
            wd = $urandom;
            step(dv, dw, da, wd, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                 fv, fa, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef MEM_TIMEOUT_EN
        check("final_bus_err", {66'h0, bus_err}, 67'h1);
`else
        check("final_bus_err", {66'h0, bus_err}, 67'h0);
`endif
        check("exp_bus_left", 67'(exp_bus_q.size()), 67'h0);
        check("exp_dm_left", 67'(exp_dm_q.size()), 67'h0);
        check("exp_if_left", 67'(exp_if_q.size()), 67'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified, variable-latency memory bus between the pipeline's instruction-fetch port (IF) and data-access port (MEM stage).
- Issues one bus transaction at a time; data has priority over fetch.
- Produces a single pipeline-freeze signal (`stall_pipe`), asserted until every pending request has completed.
- Sits between the pipelined core datapath and the external memory model.

Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `FETCH_SIZE`, 2'b00, bus size code driven for instruction fetches (word).
- `NOP_INST`, 32'h0000_0013, value of `if_rdata` after reset and on an aborted fetch.
- `TIMEOUT_CYC`, 16, maximum wait cycles for `bus_ack`; used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch address (pc).
- `if_rdata`  out  DATA_W  fetched instruction; registered.
- `if_hold`  out  1  fetch complete; data in `if_rdata` is valid.
- `dm_req`  in  1  data request (MEM-stage mreq).
- `dm_write`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_size`  in  2  byte-size code.
- `dm_rdata`  out  DATA_W  load data; registered.
- `dm_hold`  out  1  data access complete.
- `bus_req`  out  1  bus transaction active.
- `bus_write`  out  1  bus write enable.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_wdata`  out  DATA_W  bus write data.
- `bus_size`  out  2  bus size code.
- `bus_ack`  in  1  memory completes the current transaction this cycle.
- `bus_rdata`  in  DATA_W  read data, valid when `bus_ack`=1.
- `stall_pipe`  out  1  freeze PC and all pipeline registers.
- `bus_err`  out  1  sticky timeout flag.

Behaviour:
- Reset (`rst`=0, asynchronous, also mid-transaction):
  - state = IDLE.
  - `bus_req`, `bus_write`, `bus_addr`, `bus_wdata`, `bus_size` = 0.
  - `if_rdata` = NOP_INST; `dm_rdata` = 0.
  - `if_hold`, `dm_hold`, `bus_err` = 0.
  - Any in-flight transaction is abandoned; a late `bus_ack` is ignored.
- All bus outputs are registered and held stable from grant until the ack edge.
- `stall_pipe` (combinational) = `(dm_req & ~dm_hold) | (if_req & ~if_hold)`.
- States:
  - IDLE:
    - If `dm_req & ~dm_hold`: latch `dm_*` onto the bus, `bus_req`=1, go to DATA.
    - Else if `if_req & ~if_hold`: latch `if_addr`, `bus_write`=0, `bus_size`=FETCH_SIZE, `bus_req`=1, go to FETCH.
    - Else stay in IDLE.
    - `bus_ack` is ignored in IDLE.
  - DATA / FETCH:
    - Wait for `bus_ack`.
    - On the ack edge: `bus_req`=0 and the bus outputs are cleared to 0; go to IDLE.
    - DATA: set `dm_hold`. If `dm_write`=0, capture `bus_rdata` into `dm_rdata`; on a store, `dm_rdata` is unchanged.
    - FETCH: set `if_hold` and capture `bus_rdata` into `if_rdata`.
- Every transaction costs one IDLE cycle after ack; back-to-back grants are never issued.
- Hold flags:
  - On any edge where `stall_pipe`=0, clear both `if_hold` and `dm_hold`, so the pipeline advances exactly once per completed request set.
  - A set hold flag blocks re-issue of a still-asserted request.
  - `if_rdata` / `dm_rdata` are held constant while their hold flag is set.
- Latency (cycle 0 = request seen in IDLE):
  - `bus_req`=1 from cycle 1.
  - With ack in cycle 1: hold flag and rdata are valid in cycle 2, and `stall_pipe` drops in cycle 2 if nothing else is pending.
  - With both requests pending: data completes first, then fetch. Minimum `stall_pipe` duration is 4 cycles with single-cycle acks.
- Simultaneous `dm_req` and `if_req` in IDLE: DATA wins; FETCH is issued on the next IDLE cycle.
- Requests dropping mid-transaction do not abort the bus cycle; the result is still captured.
- `bus_err` = 0 when `MEM_TIMEOUT_EN` is undefined.

Optional Feature:
- Macro: `MEM_TIMEOUT_EN`.
- When defined:
  - A wait counter resets on grant and increments each DATA/FETCH cycle without `bus_ack`.
  - When it reaches TIMEOUT_CYC, the transaction aborts: `bus_req`=0, go to IDLE, set the hold flag.
  - On abort, `if_rdata`=NOP_INST for a fetch or `dm_rdata`=0 for a load; `bus_err` is set and stays set until reset.
  - An ack arriving in the same cycle as expiry wins: normal completion, no error.
- When undefined:
  - No counter; the block waits indefinitely.
  - `bus_err` is tied to 0.

Test Plan:
1. Reset release, `if_req`=1, `if_addr`=0x10000, ack in cycle 1 with `bus_rdata`=0x00500093 -> `bus_req` high in cycle 1 only, `bus_addr`=0x10000, `bus_size`=FETCH_SIZE; `if_hold`=1 and `if_rdata`=0x00500093 in cycle 2; `stall_pipe`=0 in cycle 2.
2. `dm_req`=1 (load, addr 0x2000) and `if_req`=1 together, single-cycle acks -> data bus cycle first (`bus_addr`=0x2000, `bus_write`=0), then fetch; `stall_pipe` high for exactly 4 cycles; `dm_rdata` = load value.
3. Store: `dm_write`=1, `dm_addr`=0x2004, `dm_wdata`=0xDEADBEEF, `dm_size`=2'b00, ack delayed 3 cycles -> bus outputs stable across all 4 cycles; `dm_rdata` unchanged; `dm_hold` set after ack.
4. Assert `rst`=0 while in FETCH with `bus_req`=1 -> `bus_req` drops immediately; `if_rdata`=0x13; ack pulsed after reset release is ignored; state IDLE.
5. `bus_ack` pulsed in IDLE with no requests -> no state change; both hold flags stay 0.
6. `MEM_TIMEOUT_EN` defined, TIMEOUT_CYC=16, fetch never acked -> abort after 16 wait cycles; `if_rdata`=0x13; `bus_err`=1 and remains set across later successful transactions.
